// File: rtl/serial_to_parallel_aligner.sv
// -----------------------------------------------------------------------------
// serial_to_parallel_aligner
//
// Serial-to-parallel receiver for the PHY RX path. A 1-bit stream is shifted in
// MSB first on clk_32f. The block hunts for the COMMA symbol at any bit offset,
// aligns word boundaries to it and declares the lane active after LOCK_COUNT
// consecutive aligned commas. Once active, every aligned word is presented on
// data_out with a one-cycle word_stb. valid_out additionally marks non-comma
// (payload) words.
//
// Parameters
//   WIDTH       word width in bits (>= 2)
//   COMMA       alignment / idle symbol, WIDTH bits, non-zero
//   LOCK_COUNT  consecutive aligned commas needed to go active (>= 1)
//
// Ports
//   clk_32f    in   1      bit clock, all logic on posedge
//   reset      in   1      synchronous, active-high
//   data_in    in   1      serial data, first bit of a word is its MSB
//   data_out   out  WIDTH  last aligned word seen while active (held)
//   valid_out  out  1      pulse: data_out carries a payload word
//   word_stb   out  1      pulse on every aligned word event (SYNC or ACTIVE)
//   active     out  1      lane locked
//   state_o    out  2      HUNT=0, SYNC=1, ACTIVE=2
//
// Build option
//   RX_REALIGN_EN  when defined, a comma seen off the word boundary while
//                  active forces a realign (back to SYNC with the new
//                  boundary). When undefined, alignment is frozen once active
//                  until reset.
// -----------------------------------------------------------------------------
module serial_to_parallel_aligner #(
   parameter int unsigned      WIDTH      = 8,
   parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
   parameter int unsigned      LOCK_COUNT = 4
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             word_stb,
   output logic             active,
   output logic [1:0]       state_o
);

   localparam int unsigned BW = $clog2(WIDTH);
   localparam int unsigned CW = $clog2(LOCK_COUNT + 1);

   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_COUNT);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   state_t           state_q,     state_d;
   logic [WIDTH-1:0] sr_q,        sr_d;
   logic [BW-1:0]    bit_cnt_q,   bit_cnt_d;
   logic [CW-1:0]    comma_cnt_q, comma_cnt_d;
   logic [WIDTH-1:0] data_out_q,  data_out_d;
   logic             valid_out_q, valid_out_d;
   logic             word_stb_q,  word_stb_d;
   logic             active_q,    active_d;

   logic             is_comma;
   logic             word_evt;
   logic [BW-1:0]    bit_cnt_inc;
   logic [CW-1:0]    comma_inc;

   // Shift register input, comma detect, word-event detect and counter helpers
   always_comb begin
      sr_d     = {sr_q[WIDTH-2:0], data_in};
      is_comma = (sr_d == COMMA);
      word_evt = (bit_cnt_q == LAST_BIT);
      // explicit wrap: WIDTH need not be a power of two
      if (word_evt) begin
         bit_cnt_inc = {BW{1'b0}};
      end else begin
         bit_cnt_inc = bit_cnt_q + BW'(1);
      end
      // comma count saturates at LOCK_COUNT
      if (comma_cnt_q == LOCK_MAX) begin
         comma_inc = comma_cnt_q;
      end else begin
         comma_inc = comma_cnt_q + CW'(1);
      end
   end

   // Alignment FSM: next state, counters and next output values
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_inc;
      comma_cnt_d = comma_cnt_q;
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
      word_stb_d  = 1'b0;

      case (state_q)
         ST_HUNT: begin
            // any bit offset is acceptable; the comma defines the boundary
            if (is_comma) begin
               bit_cnt_d   = {BW{1'b0}};
               comma_cnt_d = CW'(1);
               if (LOCK_COUNT == 32'd1) begin
                  state_d = ST_ACTIVE;
               end else begin
                  state_d = ST_SYNC;
               end
            end else begin
               state_d = ST_HUNT;
            end
         end

         ST_SYNC: begin
            // only word boundaries count here; mid-word commas are ignored
            if (word_evt) begin
               word_stb_d = 1'b1;
               if (is_comma) begin
                  comma_cnt_d = comma_inc;
                  if (comma_inc == LOCK_MAX) begin
                     state_d = ST_ACTIVE;
                  end else begin
                     state_d = ST_SYNC;
                  end
               end else begin
                  state_d     = ST_HUNT;
                  comma_cnt_d = {CW{1'b0}};
               end
            end else begin
               state_d = ST_SYNC;
            end
         end

         ST_ACTIVE: begin
            // payload words never break lock
            if (word_evt) begin
               data_out_d  = sr_d;
               word_stb_d  = 1'b1;
               valid_out_d = ~is_comma;
               state_d     = ST_ACTIVE;
            end
`ifdef RX_REALIGN_EN
            else if (is_comma) begin
               // comma off the boundary: adopt the new boundary and
               // re-qualify it; this comma counts as the first one
               bit_cnt_d   = {BW{1'b0}};
               comma_cnt_d = CW'(1);
               state_d     = ST_SYNC;
            end
`endif
            else begin
               state_d = ST_ACTIVE;
            end
         end

         default: begin
            state_d     = ST_HUNT;
            bit_cnt_d   = {BW{1'b0}};
            comma_cnt_d = {CW{1'b0}};
         end
      endcase

      active_d = (state_d == ST_ACTIVE);
   end

   // State, datapath and output registers; reset overrides every other event
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state_q     <= ST_HUNT;
         sr_q        <= {WIDTH{1'b0}};
         bit_cnt_q   <= {BW{1'b0}};
         comma_cnt_q <= {CW{1'b0}};
         data_out_q  <= {WIDTH{1'b0}};
         valid_out_q <= 1'b0;
         word_stb_q  <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         comma_cnt_q <= comma_cnt_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
         word_stb_q  <= word_stb_d;
         active_q    <= active_d;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;
   assign word_stb  = word_stb_q;
   assign active    = active_q;
   assign state_o   = state_q;

endmodule
